gb_cpu_fetch_unit: RTL and testbench
====================================

Name: gb_cpu_fetch_unit

Overview:
- Producer side of the instruction byte stream consumed by the CPU decoder (opcode, CB opcode, r8 immediate, r16 immediate bytes).
- Reads program bytes at the fetch PC over the memory read port and buffers them in a small prefetch FIFO.
- Presents bytes to the decoder with a valid/ready handshake; each byte carries its address.
- Flushes on control-flow redirects (JP/JR/CALL/RET/RST/interrupt).

Parameters:
- DEPTH, 2, prefetch FIFO entries (power of 2, >=2)
- RESET_PC, 16'h0000, fetch PC after reset (boot ROM entry)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- fetch_en  in  1  permit new memory requests (low during HALT/STOP or DMA)
- redirect_valid  in  1  flush and restart fetch at redirect_addr
- redirect_addr  in  16  new fetch PC
- mem_rd_req  out  1  read request, held until acknowledged
- mem_addr  out  16  read address, stable while mem_rd_req is high
- mem_rd_ack  in  1  read complete; mem_rdata is valid this cycle
- mem_rdata  in  8  read data
- byte_valid  out  1  FIFO head valid
- byte_data  out  8  FIFO head byte
- byte_pc  out  16  address of FIFO head byte
- byte_ready  in  1  decoder consumes head this cycle

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, FIFO empty, state=FETCH_IDLE, mem_rd_req=0, mem_addr=RESET_PC, byte_valid=0, byte_data=0, byte_pc=0.
- At most one outstanding memory request.
- Credit rule: issue only if fetch_en && (fifo_count + outstanding) < DEPTH. An ack therefore never meets a full FIFO.
- FSM:
  - FETCH_IDLE: if fetch_en && credit, assert mem_rd_req with mem_addr=fetch_pc, go to FETCH_WAIT.
  - FETCH_WAIT: hold req and addr. On mem_rd_ack: push {mem_rdata, mem_addr}, fetch_pc+=1, deassert req, go to FETCH_IDLE.
  - FETCH_DISCARD: an outstanding request was made stale by a redirect. Hold req and addr until mem_rd_ack, drop the data, go to FETCH_IDLE.
- mem_rd_req is registered. Minimum spacing is one request per 2 cycles: req, ack, then idle re-issue. The fast path may allow ack and re-issue on the next edge (back-to-back). Either is legal; the bench checks ordering only, not throughput.
- fetch_en deassertion never retracts an asserted req. The outstanding access completes normally.
- Output: byte_valid = FIFO non-empty; head is combinational from the FIFO registers. Pop on byte_valid && byte_ready.
- Simultaneous push and pop is allowed; count is unchanged.
- Redirect (highest priority):
  - FIFO is emptied the same edge and byte_valid=0 next cycle. A pop in the same cycle is ignored.
  - fetch_pc=redirect_addr.
  - If a request is outstanding and not acked this cycle: go to FETCH_DISCARD.
  - If acked this cycle: the ack data is dropped and the FSM goes to FETCH_IDLE.
  - Redirect while in FETCH_DISCARD: fetch_pc updates and the FSM stays in FETCH_DISCARD.
  - The first byte at redirect_addr is issued no earlier than the cycle after the stale ack.
- PC arithmetic is 16-bit modulo: 16'hFFFF+1 = 16'h0000, no flag.
- mem_rd_ack outside FETCH_WAIT/FETCH_DISCARD is ignored. The bench flags it as a protocol error.
- Reset mid-request: req drops immediately (async). Any later ack is ignored in FETCH_IDLE.

Decomposition:
- Add fetch_state_t (FETCH_IDLE, FETCH_WAIT, FETCH_DISCARD; logic [1:0]) to gb_cpu_common_pkg.
- Add struct fetch_byte_t {logic [7:0] data; logic [15:0] pc;} to gb_cpu_common_pkg.
- Sub-module gb_cpu_fetch_fifo: DEPTH-entry fetch_byte_t FIFO with push/pop/flush, count output, pointer wrap at DEPTH. Flush dominates push and pop.
- FSM, PC and credit logic live in gb_cpu_fetch_unit.

Test Plan:
1. Reset release with memory acking 1 cycle after req, byte_ready=1 -> mem_addr sequence 0000,0001,0002; bytes emerge in order with matching byte_pc; no duplicates or gaps.
2. byte_ready=0 for 20 cycles from PC 0100 -> exactly 2 requests (0100,0101); mem_rd_req then stays low. Raise ready: bytes 0100,0101 pop, fetch resumes at 0102.
3. Redirect to 0x0038 while a request to 0x0150 is pending, ack 3 cycles later -> 0x0150 data never appears on byte_*; next mem_addr is 0038; first byte_pc=0038.
4. Redirect to 0x1234 in the same cycle as ack of 0x0200 with byte_valid && byte_ready -> FIFO empty next cycle; 0x0200 data dropped; next request 1234.
5. Redirect to FFFE, run 4 bytes -> mem_addr FFFE, FFFF, 0000, 0001.
6. fetch_en dropped while a request is pending -> that ack is still buffered; no new req while low. Separately, rst_n pulsed low mid-request -> req low asynchronously and fetch restarts at 0000.

Source files
------------

// File: rtl/gb_cpu_common_pkg.sv
// Shared types for the CPU front end.
// Fetch FSM state encoding and the prefetch byte bundle.
package gb_cpu_common_pkg;

   typedef enum logic [1:0] {
      FETCH_IDLE    = 2'd0,
      FETCH_WAIT    = 2'd1,
      FETCH_DISCARD = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [7:0]  data;
      logic [15:0] pc;
   } fetch_byte_t;

endpackage

// File: rtl/gb_cpu_fetch_fifo.sv
// Prefetch FIFO of instruction bytes with their addresses.
// Ports: push/push_byte in, pop in, flush in, head/count out.
module gb_cpu_fetch_fifo
   import gb_cpu_common_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  fetch_byte_t   push_byte,
   input  logic          pop,
   output fetch_byte_t   head,
   output logic [CW-1:0] count
);

   fetch_byte_t   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   function automatic logic [AW-1:0] next_ptr(
      input logic [AW-1:0] p
   );
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign do_push = push && (count_q != CW'(DEPTH));
   assign do_pop  = pop && (count_q != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr] <= push_byte;
            wr_ptr        <= next_ptr(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         if (do_push && !do_pop) begin
            count_q <= count_q + 1'b1;
         end else if (do_pop && !do_push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   assign head  = mem_q[rd_ptr];
   assign count = count_q;

endmodule

// File: rtl/gb_cpu_fetch_unit.sv
// Instruction byte fetch: memory read FSM, fetch PC, prefetch FIFO.
// Ports: redirect in, mem read port, byte valid/ready stream out.
module gb_cpu_fetch_unit
   import gb_cpu_common_pkg::*;
#(
   parameter int          DEPTH    = 2,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_addr,
   output logic        mem_rd_req,
   output logic [15:0] mem_addr,
   input  logic        mem_rd_ack,
   input  logic [7:0]  mem_rdata,
   output logic        byte_valid,
   output logic [7:0]  byte_data,
   output logic [15:0] byte_pc,
   input  logic        byte_ready
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t  state_q;
   fetch_state_t  state_d;
   logic [15:0]   fetch_pc_q;
   logic [CW-1:0] fifo_count;
   logic [CW:0]   inflight;
   logic          outstanding;
   logic          credit;
   logic          issue;
   logic          push;
   logic          pop;
   fetch_byte_t   push_byte;
   fetch_byte_t   head;

   // Buffered bytes plus the one in flight must fit, so an ack
   // can always be pushed.
   assign outstanding = (state_q != FETCH_IDLE);
   assign inflight    = {1'b0, fifo_count}
                      + {{CW{1'b0}}, outstanding};
   assign credit      = inflight < (CW + 1)'(DEPTH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FETCH_IDLE: begin
            if (issue) state_d = FETCH_WAIT;
         end
         FETCH_WAIT: begin
            if (mem_rd_ack) begin
               state_d = FETCH_IDLE;
            end else if (redirect_valid) begin
               state_d = FETCH_DISCARD;
            end
         end
         FETCH_DISCARD: begin
            if (mem_rd_ack) state_d = FETCH_IDLE;
         end
         default: state_d = FETCH_IDLE;
      endcase
   end

   // Nothing is issued on a redirect edge; the new PC is
   // only visible from the next cycle.
   always_comb begin
      issue = 1'b0;
      push  = 1'b0;
      unique case (1'b1)
         state_q == FETCH_IDLE:
            issue = fetch_en && credit && !redirect_valid;
         state_q == FETCH_WAIT:
            push = mem_rd_ack && !redirect_valid;
         default: ;
      endcase
   end

   assign pop = byte_valid && byte_ready && !redirect_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         mem_rd_req <= 1'b0;
         mem_addr   <= RESET_PC;
      end else begin
         mem_rd_req <= (state_d != FETCH_IDLE);
         if (issue) mem_addr <= fetch_pc_q;
         if (redirect_valid) begin
            fetch_pc_q <= redirect_addr;
         end else if (push) begin
            fetch_pc_q <= fetch_pc_q + 16'd1;
         end
      end
   end

   assign push_byte = '{data: mem_rdata, pc: mem_addr};

   gb_cpu_fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .push      (push),
      .push_byte (push_byte),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count)
   );

   assign byte_valid = (fifo_count != '0);
   assign byte_data  = head.data;
   assign byte_pc    = head.pc;

endmodule

// File: tb/tb_gb_cpu_fetch_unit.sv
// Directed bench for gb_cpu_fetch_unit.
// Memory responder, pop/ack monitors, one task per scenario.
module tb_gb_cpu_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        fetch_en = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_addr = 16'h0000;
   logic        mem_rd_req;
   logic [15:0] mem_addr;
   logic        mem_rd_ack;
   logic [7:0]  mem_rdata;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic [15:0] byte_pc;
   logic        byte_ready = 1'b0;

   bit          auto_mode = 1'b1;
   logic        force_ack = 1'b0;
   logic        ack_r = 1'b0;
   int          lat_cnt = 0;
   int          proto_err = 0;

   logic [15:0] ack_q[$];
   logic [15:0] pop_pc_q[$];
   logic [7:0]  pop_dat_q[$];

   int errors = 0;
   int checks = 0;
   int a0 = 0;
   int p0 = 0;

   always #5 clk = ~clk;

   function automatic logic [7:0] mdata(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   assign mem_rdata  = mdata(mem_addr);
   assign mem_rd_ack = auto_mode ? ack_r : force_ack;

   gb_cpu_fetch_unit #(
      .DEPTH    (2),
      .RESET_PC (16'h0000)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .mem_rd_req     (mem_rd_req),
      .mem_addr       (mem_addr),
      .mem_rd_ack     (mem_rd_ack),
      .mem_rdata      (mem_rdata),
      .byte_valid     (byte_valid),
      .byte_data      (byte_data),
      .byte_pc        (byte_pc),
      .byte_ready     (byte_ready)
   );

   // Auto memory: ack one cycle after the request is seen.
   always @(posedge clk) begin
      if (!auto_mode || !rst_n) begin
         ack_r   <= 1'b0;
         lat_cnt <= 0;
      end else if (ack_r) begin
         ack_r <= 1'b0;
      end else if (mem_rd_req) begin
         ack_r <= 1'b1;
      end
   end

   always @(posedge clk) begin
      if (rst_n) begin
         if (mem_rd_ack && mem_rd_req) ack_q.push_back(mem_addr);
         if (mem_rd_ack && !mem_rd_req) proto_err++;
         if (byte_valid && byte_ready && !redirect_valid) begin
            pop_pc_q.push_back(byte_pc);
            pop_dat_q.push_back(byte_data);
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_req(input logic [15:0] a, input string nm);
      bit f;
      f = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (mem_rd_req && mem_addr == a) begin
            f = 1'b1;
            break;
         end
      end
      checks++;
      if (!f) begin
         errors++;
         $display("FAIL %s: no req to %h (got req=%b addr=%h)",
                  nm, a, mem_rd_req, mem_addr);
      end
   endtask

   task automatic restart(input logic [15:0] a, input bit auto_after);
      bit f;
      fetch_en  = 1'b0;
      force_ack = 1'b0;
      auto_mode = 1'b1;
      f = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (!mem_rd_req) begin
            f = 1'b1;
            break;
         end
      end
      checks++;
      if (!f) begin
         errors++;
         $display("FAIL restart_idle: req=%b required 0", mem_rd_req);
      end
      redirect_valid = 1'b1;
      redirect_addr  = a;
      @(negedge clk);
      redirect_valid = 1'b0;
      auto_mode = auto_after;
      a0 = ack_q.size();
      p0 = pop_pc_q.size();
      fetch_en = 1'b1;
   endtask

   task automatic test_reset;
      #2 rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({mem_rd_req, mem_addr, byte_valid, byte_data, byte_pc}
          !== {1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000}) begin
         errors++;
         $display("FAIL reset_outputs: req=%b addr=%h v=%b d=%h pc=%h required 0/0000/0/00/0000",
                  mem_rd_req, mem_addr, byte_valid, byte_data, byte_pc);
      end
   endtask

   task automatic test_stream;
      int bad;
      fetch_en   = 1'b1;
      byte_ready = 1'b1;
      a0 = ack_q.size();
      p0 = pop_pc_q.size();
      @(negedge clk);
      rst_n = 1'b1;
      cycles(20);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (ack_q[a0+i] !== 16'(i)) begin
            errors++;
            $display("FAIL stream_addr%0d: got %h required %h",
                     i, ack_q[a0+i], 16'(i));
         end
         checks++;
         if (pop_pc_q[p0+i] !== 16'(i) ||
             pop_dat_q[p0+i] !== mdata(16'(i))) begin
            errors++;
            $display("FAIL stream_byte%0d: got pc=%h d=%h required pc=%h d=%h",
                     i, pop_pc_q[p0+i], pop_dat_q[p0+i],
                     16'(i), mdata(16'(i)));
         end
      end
      bad = 0;
      for (int i = p0 + 1; i < pop_pc_q.size(); i++) begin
         if (pop_pc_q[i] !== pop_pc_q[i-1] + 16'd1) bad++;
      end
      checks++;
      if (bad != 0 || pop_pc_q.size() - p0 < 4) begin
         errors++;
         $display("FAIL stream_order: gaps=%0d pops=%0d required 0 gaps, >=4 pops",
                  bad, pop_pc_q.size() - p0);
      end
   endtask

   task automatic test_backpressure;
      byte_ready = 1'b0;
      restart(16'h0100, 1'b1);
      cycles(20);
      checks++;
      if (ack_q.size() - a0 != 2 || ack_q[a0] !== 16'h0100 ||
          ack_q[a0+1] !== 16'h0101) begin
         errors++;
         $display("FAIL bp_reqs: n=%0d a=%h,%h required 2 0100,0101",
                  ack_q.size() - a0, ack_q[a0], ack_q[a0+1]);
      end
      checks++;
      if (mem_rd_req !== 1'b0 || byte_valid !== 1'b1 ||
          byte_pc !== 16'h0100) begin
         errors++;
         $display("FAIL bp_stall: req=%b v=%b pc=%h required 0/1/0100",
                  mem_rd_req, byte_valid, byte_pc);
      end
      byte_ready = 1'b1;
      cycles(12);
      checks++;
      if (pop_pc_q[p0] !== 16'h0100 || pop_pc_q[p0+1] !== 16'h0101 ||
          pop_pc_q[p0+2] !== 16'h0102) begin
         errors++;
         $display("FAIL bp_resume_pops: %h,%h,%h required 0100,0101,0102",
                  pop_pc_q[p0], pop_pc_q[p0+1], pop_pc_q[p0+2]);
      end
      checks++;
      if (ack_q[a0+2] !== 16'h0102) begin
         errors++;
         $display("FAIL bp_resume_req: got %h required 0102", ack_q[a0+2]);
      end
   endtask

   task automatic test_redirect_pending;
      byte_ready = 1'b1;
      restart(16'h0150, 1'b0);
      wait_req(16'h0150, "rp_req");
      redirect_valid = 1'b1;
      redirect_addr  = 16'h0038;
      @(negedge clk);
      redirect_valid = 1'b0;
      checks++;
      if (mem_rd_req !== 1'b1 || mem_addr !== 16'h0150 ||
          byte_valid !== 1'b0) begin
         errors++;
         $display("FAIL rp_discard_hold: req=%b addr=%h v=%b required 1/0150/0",
                  mem_rd_req, mem_addr, byte_valid);
      end
      cycles(2);
      force_ack = 1'b1;
      @(negedge clk);
      force_ack = 1'b0;
      auto_mode = 1'b1;
      cycles(15);
      checks++;
      if (ack_q[a0] !== 16'h0150 || ack_q[a0+1] !== 16'h0038) begin
         errors++;
         $display("FAIL rp_addrs: %h,%h required 0150,0038",
                  ack_q[a0], ack_q[a0+1]);
      end
      checks++;
      if (pop_pc_q[p0] !== 16'h0038 ||
          pop_dat_q[p0] !== mdata(16'h0038)) begin
         errors++;
         $display("FAIL rp_first_byte: pc=%h d=%h required 0038/%h",
                  pop_pc_q[p0], pop_dat_q[p0], mdata(16'h0038));
      end
   endtask

   task automatic test_redirect_on_ack;
      byte_ready = 1'b0;
      restart(16'h01FF, 1'b0);
      wait_req(16'h01FF, "ra_req0");
      force_ack = 1'b1;
      @(negedge clk);
      force_ack = 1'b0;
      wait_req(16'h0200, "ra_req1");
      byte_ready     = 1'b1;
      force_ack      = 1'b1;
      redirect_valid = 1'b1;
      redirect_addr  = 16'h1234;
      @(negedge clk);
      force_ack      = 1'b0;
      redirect_valid = 1'b0;
      checks++;
      if (byte_valid !== 1'b0 || mem_rd_req !== 1'b0) begin
         errors++;
         $display("FAIL ra_flush: v=%b req=%b required 0/0",
                  byte_valid, mem_rd_req);
      end
      auto_mode = 1'b1;
      cycles(12);
      checks++;
      if (ack_q[a0+2] !== 16'h1234) begin
         errors++;
         $display("FAIL ra_next_req: got %h required 1234", ack_q[a0+2]);
      end
      checks++;
      if (pop_pc_q.size() <= p0 || pop_pc_q[p0] !== 16'h1234) begin
         errors++;
         $display("FAIL ra_first_byte: got %h required 1234", pop_pc_q[p0]);
      end
   endtask

   task automatic test_wrap;
      byte_ready = 1'b1;
      restart(16'hFFFE, 1'b1);
      cycles(20);
      checks++;
      if (ack_q[a0] !== 16'hFFFE || ack_q[a0+1] !== 16'hFFFF ||
          ack_q[a0+2] !== 16'h0000 || ack_q[a0+3] !== 16'h0001) begin
         errors++;
         $display("FAIL wrap_addrs: %h,%h,%h,%h required FFFE,FFFF,0000,0001",
                  ack_q[a0], ack_q[a0+1], ack_q[a0+2], ack_q[a0+3]);
      end
      checks++;
      if (pop_pc_q[p0+1] !== 16'hFFFF || pop_pc_q[p0+2] !== 16'h0000 ||
          pop_dat_q[p0+2] !== mdata(16'h0000)) begin
         errors++;
         $display("FAIL wrap_bytes: pc=%h,%h d=%h required FFFF,0000 d=%h",
                  pop_pc_q[p0+1], pop_pc_q[p0+2], pop_dat_q[p0+2],
                  mdata(16'h0000));
      end
   endtask

   task automatic test_fetch_en_and_reset;
      byte_ready = 1'b0;
      restart(16'h0300, 1'b0);
      wait_req(16'h0300, "fe_req");
      fetch_en = 1'b0;
      cycles(2);
      checks++;
      if (mem_rd_req !== 1'b1 || mem_addr !== 16'h0300) begin
         errors++;
         $display("FAIL fe_hold: req=%b addr=%h required 1/0300",
                  mem_rd_req, mem_addr);
      end
      force_ack = 1'b1;
      @(negedge clk);
      force_ack = 1'b0;
      checks++;
      if (byte_valid !== 1'b1 || byte_pc !== 16'h0300 ||
          byte_data !== mdata(16'h0300)) begin
         errors++;
         $display("FAIL fe_buffered: v=%b pc=%h d=%h required 1/0300/%h",
                  byte_valid, byte_pc, byte_data, mdata(16'h0300));
      end
      cycles(5);
      checks++;
      if (mem_rd_req !== 1'b0) begin
         errors++;
         $display("FAIL fe_no_issue: req=%b required 0", mem_rd_req);
      end
      fetch_en = 1'b1;
      wait_req(16'h0301, "rst_req");
      rst_n = 1'b0;
      #1;
      checks++;
      if (mem_rd_req !== 1'b0 || byte_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_async: req=%b v=%b required 0/0",
                  mem_rd_req, byte_valid);
      end
      @(negedge clk);
      rst_n      = 1'b1;
      auto_mode  = 1'b1;
      byte_ready = 1'b1;
      a0 = ack_q.size();
      p0 = pop_pc_q.size();
      cycles(15);
      checks++;
      if (ack_q[a0] !== 16'h0000 || pop_pc_q[p0] !== 16'h0000) begin
         errors++;
         $display("FAIL rst_restart: addr=%h pc=%h required 0000/0000",
                  ack_q[a0], pop_pc_q[p0]);
      end
   endtask

   task automatic test_protocol;
      checks++;
      if (proto_err != 0) begin
         errors++;
         $display("FAIL protocol: stray acks=%0d required 0", proto_err);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_pending();
      test_redirect_on_ack();
      test_wrap();
      test_fetch_en_and_reset();
      test_protocol();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1);
   end

endmodule
